// File: rtl/if_fetch_pkg.sv
// Shared widths, stall encodings, reset vector and hold-FSM state type for the IF stage.
// Everything IF and its neighbours agree on lives here so the stage files stay define-free.
package if_fetch_pkg;

    localparam int STALL_W     = 6;
    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    typedef enum logic {
        HOLD_RUN  = 1'b0,
        HOLD_HOLD = 1'b1
    } hold_state_e;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_inst_hold.sv
// Keeps the instruction word seen by ID stable across IF/ID stalls.
// The SRAM re-reads a frozen PC while stalled, so its output is no longer ID's instruction.
module if_inst_hold
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic [31:0] rdata,
    output logic [31:0] inst,
    output logic        hold_valid
);

    hold_state_e state_q, state_d;
    logic [31:0] hold_q, hold_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HOLD_RUN;
            hold_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            HOLD_RUN: begin
                if (stall_id == STOP) begin
                    hold_d  = rdata;
                    state_d = HOLD_HOLD;
                end
            end
            HOLD_HOLD: begin
                // Released data for the next PC shows up one cycle later, exactly when RUN resumes.
                if (stall_id == NO_STOP) begin
                    state_d = HOLD_RUN;
                end
            end
            default: state_d = HOLD_RUN;
        endcase
    end

    assign hold_valid = (state_q == HOLD_HOLD);
    assign inst       = hold_valid ? hold_q : rdata;

endmodule

// File: rtl/if_fetch.sv
// IF stage: owns the PC, drives the synchronous instruction SRAM, applies ID branch redirects
// and hands {ce, pc} plus a stall-stable instruction word to ID.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [31:0]            id_inst,
    output logic [CNT_W-1:0]       fetch_cnt
);

    // Handshake: ce is IF's valid for {pc, inst}; stall[0]/stall[1] are the backpressure from CTRL.
    // A word moves only on a posedge with ce=1 and the matching stall bit at NO_STOP; while stalled
    // IF holds pc, ce and the instruction word unchanged.
    logic              br_e;
    logic [31:0]       br_addr;
    logic [31:0]       next_pc;
    logic [31:0]       pc_q, pc_d;
    logic              ce_q, ce_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hold_valid;
    logic              unused_stall;

    assign br_e         = br_bus[32];
    assign br_addr      = br_bus[31:0];
    assign unused_stall = &{1'b0, stall[STALL_W-1:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ce_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ce_q  <= ce_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        next_pc = br_e ? br_addr : seq_pc(pc_q);
        pc_d    = pc_q;
        ce_d    = ce_q;
        cnt_d   = cnt_q;
        // A branch seen during a PC stall is dropped; ID re-presents it once the stall lifts.
        if (stall[0] == NO_STOP) begin
            pc_d = next_pc;
            ce_d = 1'b1;
            if (ce_q) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign inst_sram_en    = ce_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'd0;
    assign if_to_id_bus    = {ce_q, pc_q};
    assign fetch_cnt       = cnt_q;

    if_inst_hold u_hold (
        .clk        (clk),
        .rst        (rst),
        .stall_id   (stall[1]),
        .rdata      (inst_sram_rdata),
        .inst       (id_inst),
        .hold_valid (hold_valid)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for the IF stage: reset, sequential fetch, redirects, stall hold, wrap and mid-hold reset.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic [32:0] if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] id_inst;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    if_fetch #(.CNT_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .br_bus          (br_bus),
        .if_to_id_bus    (if_to_id_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_inst         (id_inst),
        .fetch_cnt       (fetch_cnt)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 6'b0; br_bus = 33'd0; inst_sram_rdata = 32'hDEAD_BEEF;
        tick(); tick();
        checks++;
        if (if_to_id_bus !== {1'b0, 32'hBFBF_FFFC}) begin
            errors++; $display("FAIL reset_bus: got %h expected %h", if_to_id_bus, {1'b0, 32'hBFBF_FFFC});
        end
        checks++;
        if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'hBFBF_FFFC) begin
            errors++; $display("FAIL reset_sram: got en=%b addr=%h expected en=0 addr=bfbffffc", inst_sram_en, inst_sram_addr);
        end
        checks++;
        if (inst_sram_wen !== 4'b0000 || inst_sram_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_wr: got wen=%b wdata=%h expected 0/0", inst_sram_wen, inst_sram_wdata);
        end
        checks++;
        if (id_inst !== 32'hDEAD_BEEF || fetch_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_inst_cnt: got inst=%h cnt=%0d expected deadbeef/0", id_inst, fetch_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        exp_q = '{32'hBFBF_FFFC, 32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
        // Cycle 1 after reset release is still the reset PC with ce=0.
        for (int i = 0; i < 4; i++) begin
            exp_pc = exp_q.pop_front();
            checks++;
            if (if_to_id_bus !== {(i != 0), exp_pc}) begin
                errors++; $display("FAIL free_run_pc%0d: got %h expected %h", i, if_to_id_bus, {(i != 0), exp_pc});
            end
            tick();
        end
        checks++;
        if (fetch_cnt !== 32'd3 || inst_sram_addr !== 32'hBFC0_000C) begin
            errors++; $display("FAIL free_run_cnt: got cnt=%0d addr=%h expected 3/bfc0000c", fetch_cnt, inst_sram_addr);
        end
    endtask

    task automatic test_branch();
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0010) begin
            errors++; $display("FAIL branch_pre: got %h expected bfc00010", inst_sram_addr);
        end
        br_bus = {1'b1, 32'hBFC0_0100};
        tick();
        br_bus = 33'd0;
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0100) begin
            errors++; $display("FAIL branch_target: got %h expected bfc00100", inst_sram_addr);
        end
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0104 || fetch_cnt !== 32'd6) begin
            errors++; $display("FAIL branch_seq: got addr=%h cnt=%0d expected bfc00104/6", inst_sram_addr, fetch_cnt);
        end
    endtask

    task automatic test_stall_hold();
        br_bus = {1'b1, 32'hBFC0_0020};
        tick();
        br_bus = 33'd0;
        inst_sram_rdata = 32'h8C22_0000;
        stall = 6'b000011;
        #1;
        checks++;
        if (id_inst !== 32'h8C22_0000) begin
            errors++; $display("FAIL hold_pass: got %h expected 8c220000", id_inst);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            inst_sram_rdata = 32'h1234_5678;
            if (i == 2) stall = 6'b000000;
            #1;
            checks++;
            if (id_inst !== 32'h8C22_0000 || inst_sram_addr !== 32'hBFC0_0020 || fetch_cnt !== 32'd7) begin
                errors++; $display("FAIL hold_cycle%0d: got inst=%h addr=%h cnt=%0d expected 8c220000/bfc00020/7",
                                   i, id_inst, inst_sram_addr, fetch_cnt);
            end
        end
        tick();
        inst_sram_rdata = 32'h2002_0004;
        #1;
        checks++;
        if (id_inst !== 32'h2002_0004 || inst_sram_addr !== 32'hBFC0_0024 || fetch_cnt !== 32'd8) begin
            errors++; $display("FAIL hold_release: got inst=%h addr=%h cnt=%0d expected 20020004/bfc00024/8",
                               id_inst, inst_sram_addr, fetch_cnt);
        end
    endtask

    task automatic test_branch_during_stall();
        stall = 6'b000001;
        br_bus = {1'b1, 32'hBFC0_0200};
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0024 || fetch_cnt !== 32'd8) begin
            errors++; $display("FAIL br_stall_frozen: got addr=%h cnt=%0d expected bfc00024/8", inst_sram_addr, fetch_cnt);
        end
        stall = 6'b0;
        br_bus = 33'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0028 || fetch_cnt !== 32'd9) begin
            errors++; $display("FAIL br_stall_release: got addr=%h cnt=%0d expected bfc00028/9", inst_sram_addr, fetch_cnt);
        end
    endtask

    task automatic test_pc_wrap();
        br_bus = {1'b1, 32'hFFFF_FFFC};
        tick();
        br_bus = 33'd0;
        tick();
        checks++;
        if (inst_sram_addr !== 32'h0000_0000 || fetch_cnt !== 32'd11) begin
            errors++; $display("FAIL pc_wrap: got addr=%h cnt=%0d expected 00000000/11", inst_sram_addr, fetch_cnt);
        end
    endtask

    task automatic test_reset_in_hold();
        inst_sram_rdata = 32'hAAAA_5555;
        stall = 6'b000011;
        tick();
        checks++;
        if (dut.u_hold.hold_valid !== 1'b1) begin
            errors++; $display("FAIL rst_hold_enter: got hold_valid=%b expected 1", dut.u_hold.hold_valid);
        end
        rst = 1'b1;
        inst_sram_rdata = 32'h0F0F_0F0F;
        tick();
        rst = 1'b0;
        stall = 6'b0;
        #1;
        checks++;
        if (dut.u_hold.hold_valid !== 1'b0 || dut.u_hold.hold_q !== 32'd0 || id_inst !== 32'h0F0F_0F0F) begin
            errors++; $display("FAIL rst_hold_clear: got hv=%b hd=%h inst=%h expected 0/00000000/0f0f0f0f",
                               dut.u_hold.hold_valid, dut.u_hold.hold_q, id_inst);
        end
        checks++;
        if (if_to_id_bus !== {1'b0, 32'hBFBF_FFFC} || fetch_cnt !== 32'd0) begin
            errors++; $display("FAIL rst_hold_pc: got bus=%h cnt=%0d expected 0bfbffffc/0", if_to_id_bus, fetch_cnt);
        end
    endtask

    task automatic test_first_cycle_branch();
        br_bus = {1'b1, 32'h1000_0000};
        tick();
        br_bus = 33'd0;
        checks++;
        if (if_to_id_bus !== {1'b1, 32'h1000_0000} || fetch_cnt !== 32'd0) begin
            errors++; $display("FAIL first_branch: got bus=%h cnt=%0d expected 110000000/0", if_to_id_bus, fetch_cnt);
        end
        tick();
        checks++;
        if (inst_sram_addr !== 32'h1000_0004 || fetch_cnt !== 32'd1) begin
            errors++; $display("FAIL first_branch_seq: got addr=%h cnt=%0d expected 10000004/1", inst_sram_addr, fetch_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch();
        test_stall_hold();
        test_branch_during_stall();
        test_pc_wrap();
        test_reset_in_hold();
        test_first_cycle_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
